// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: multi-cycle instruction-fetch controller.
// Reads curPC, fetches one instruction word via a req/ack memory port,
// presents it to decode with a valid/ready handshake, then pulses PCWre
// with either the sequential PC or a branch/jump redirect target.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt / flush_cnt counters.
module if_fetch_ctrl #(
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] curPC,
   output logic        PCWre,
   output logic [31:0] nextPC,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        ir_valid,
   output logic [31:0] IR,
   input  logic        id_ready,
   input  logic        redir_valid,
   input  logic [31:0] redir_target
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } state_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_t      state_q;
   logic        pcWre_q;
   logic [31:0] nextPc_q;
   logic        memReq_q;
   logic        irValid_q;
   logic [31:0] ir_q;
   logic        redirPend_q;
   logic [31:0] pendTarget_q;

   logic [31:0] seqPc_d;
   logic [31:0] holdRedirPc_d;
   logic [31:0] reqRedirPc_d;
   logic        ackSeen_d;
   logic        discard_d;

   // Candidate next-PC values, all forced word aligned; a redirect arriving
   // together with the ack overrides any older pending target.
   always_comb begin
      seqPc_d       = (curPC + PC_STEP) & WORD_MASK;
      holdRedirPc_d = redir_target & WORD_MASK;
      reqRedirPc_d  = (redir_valid ? redir_target : pendTarget_q) & WORD_MASK;
      ackSeen_d     = (state_q == S_REQ) && memReq_q && mem_ack;
      discard_d     = ackSeen_d && (redirPend_q || redir_valid);
   end

   // Fetch FSM with registered outputs. mem_req is held low during every
   // PCWre cycle so a request is never issued against a stale curPC; acks
   // seen while mem_req is low are ignored.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         pcWre_q      <= 1'b0;
         nextPc_q     <= 32'h0;
         memReq_q     <= 1'b0;
         irValid_q    <= 1'b0;
         ir_q         <= RESET_IR;
         redirPend_q  <= 1'b0;
         pendTarget_q <= 32'h0;
      end else begin
         pcWre_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               state_q  <= S_REQ;
               memReq_q <= 1'b1;
            end
            S_REQ: begin
               if (discard_d) begin
                  pcWre_q     <= 1'b1;
                  nextPc_q    <= reqRedirPc_d;
                  redirPend_q <= 1'b0;
                  memReq_q    <= 1'b0;
               end else if (ackSeen_d) begin
                  ir_q      <= mem_rdata;
                  irValid_q <= 1'b1;
                  memReq_q  <= 1'b0;
                  state_q   <= S_HOLD;
               end else begin
                  memReq_q <= 1'b1;
                  if (redir_valid) begin
                     redirPend_q  <= 1'b1;
                     pendTarget_q <= redir_target;
                  end
               end
            end
            S_HOLD: begin
               if (redir_valid) begin
                  pcWre_q   <= 1'b1;
                  nextPc_q  <= holdRedirPc_d;
                  irValid_q <= 1'b0;
                  ir_q      <= RESET_IR;
                  state_q   <= S_REQ;
               end else if (id_ready) begin
                  pcWre_q   <= 1'b1;
                  nextPc_q  <= seqPc_d;
                  irValid_q <= 1'b0;
                  state_q   <= S_REQ;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               memReq_q <= 1'b0;
            end
         endcase
      end
   end

   assign PCWre    = pcWre_q;
   assign nextPC   = nextPc_q;
   assign mem_req  = memReq_q;
   assign mem_addr = {curPC[31:2], 2'b00};
   assign ir_valid = irValid_q;
   assign IR       = ir_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetchCnt_q;
   logic [31:0] flushCnt_q;
   logic        handshake_d;
   logic        flushEvt_d;

   // Event strobes for the counters: accepted instructions and discarded work.
   always_comb begin
      handshake_d = (state_q == S_HOLD) && id_ready && !redir_valid;
      flushEvt_d  = ((state_q == S_HOLD) && redir_valid) || discard_d;
   end

   // Free-running wrap-around performance counters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetchCnt_q <= 32'h0;
         flushCnt_q <= 32'h0;
      end else begin
         if (handshake_d) fetchCnt_q <= fetchCnt_q + 32'd1;
         if (flushEvt_d)  flushCnt_q <= flushCnt_q + 32'd1;
      end
   end

   assign fetch_cnt = fetchCnt_q;
   assign flush_cnt = flushCnt_q;
`endif

endmodule
